// File: rtl/actor_tile_mover_if.sv
// Tile-map access port: read request/response (get/ready/read_sprite) and write strobe.
// Single-beat: get holds until ready; update is a one-cycle write with posx/posy/sprite valid.
interface actor_tile_mover_if #(
  parameter int COORD_W = 6
);
  logic               get;
  logic               ready;
  logic [7:0]         read_sprite;
  logic               update;
  logic [7:0]         sprite;
  logic [COORD_W-1:0] posx;
  logic [COORD_W-1:0] posy;

  modport master (
    output get, update, sprite, posx, posy,
    input  ready, read_sprite
  );

  modport slave (
    input  get, update, sprite, posx, posy,
    output ready, read_sprite
  );
endinterface

// File: rtl/actor_tile_mover.sv
// Steps NUM_ACTORS actors one tile every MAXFRAMES+1 frames, wall-checked via the map read port.
// Per actor 3 cycles (still/blocked) or 6 + ready wait (moving); READ stalls until ready.
module actor_tile_mover #(
  parameter int         NUM_ACTORS  = 4,
  parameter int         MAP_W       = 40,
  parameter int         MAP_H       = 30,
  parameter int         COORD_W     = 6,
  parameter int         MAXFRAMES   = 20,
  parameter int         WRAP        = 1,
  parameter logic [7:0] WALL_CODE   = 8'd1,
  parameter logic [7:0] EMPTY_CODE  = 8'd0,
  parameter logic [7:0] ALT_CODE    = 8'd3,
  parameter logic [4:0] SPRITE_BASE = 5'd2,
  parameter int         START_X     = 6,
  parameter int         START_Y     = 6,
  parameter int         START_STEP  = 2
) (
  input  logic                    px_clk,
  input  logic                    rst,
  input  logic                    endframe,
  input  logic [4*NUM_ACTORS-1:0] dir,
  actor_tile_mover_if.master      map,
  output logic                    busy
);

  localparam int IDX_W = (NUM_ACTORS > 1) ? $clog2(NUM_ACTORS) : 1;
  localparam int CNT_W = (MAXFRAMES > 0) ? $clog2(MAXFRAMES + 1) : 1;
  localparam int SW    = COORD_W + 1;

  localparam logic [2:0] OR_RIGHT = 3'b000;
  localparam logic [2:0] OR_UP    = 3'b001;
  localparam logic [2:0] OR_DOWN  = 3'b010;
  localparam logic [2:0] OR_LEFT  = 3'b011;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_ERASE = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_DRAW  = 3'd6;
  localparam logic [2:0] S_NEXT  = 3'd7;

  localparam logic signed [SW-1:0] MW     = SW'(MAP_W);
  localparam logic signed [SW-1:0] MH     = SW'(MAP_H);
  localparam logic signed [SW-1:0] S_ONE  = SW'(1);
  localparam logic signed [SW-1:0] S_MONE = '1;
  localparam logic signed [SW-1:0] S_ZERO = '0;
  localparam logic [COORD_W-1:0]   MW_M1  = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0]   MH_M1  = COORD_W'(MAP_H - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAXFRAMES);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_ACTORS - 1);

  logic               endframe_q;
  logic               frame_rise;
  logic [CNT_W-1:0]   frame_cnt;
  logic               tick;
  logic               blink;
  logic               pending;

  logic [2:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [COORD_W-1:0] act_x   [NUM_ACTORS];
  logic [COORD_W-1:0] act_y   [NUM_ACTORS];
  logic [2:0]         act_or  [NUM_ACTORS];
  logic [COORD_W-1:0] tgt_x, tgt_y;
  logic [COORD_W-1:0] old_x, old_y;
  logic [7:0]         rd_q;

  logic [3:0]         dir_sel;
  logic               calc_any;
  logic               calc_block;
  logic [2:0]         calc_or;
  logic signed [SW-1:0] cur_x, cur_y, dx, dy, nx, ny;
  logic               off_x, off_y;
  logic [COORD_W-1:0] calc_tx, calc_ty;
  logic [4:0]         body;

  assign frame_rise = endframe & ~endframe_q;
  assign tick       = frame_rise && (frame_cnt == CNT_MAX);

  // Frame divider, blink phase and the one-deep tick request.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      endframe_q <= 1'b0;
      frame_cnt  <= '0;
      blink      <= 1'b0;
      pending    <= 1'b0;
    end else begin
      endframe_q <= endframe;
      if (frame_rise) begin
        if (frame_cnt == CNT_MAX) frame_cnt <= '0;
        else                      frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (tick && !pending) begin
        pending <= 1'b1;
        blink   <= ~blink;
      end else if (state == S_IDLE && pending) begin
        pending <= 1'b0;
      end
    end
  end

  // Target tile for the actor being serviced; left > right > up > down.
  always_comb begin
    dir_sel  = dir[{idx, 2'b00} +: 4];
    calc_any = |dir_sel;
    calc_or  = act_or[idx];
    dx       = S_ZERO;
    dy       = S_ZERO;
    if (dir_sel[3]) begin
      dx      = S_MONE;
      calc_or = OR_LEFT;
    end else if (dir_sel[2]) begin
      dx      = S_ONE;
      calc_or = OR_RIGHT;
    end else if (dir_sel[1]) begin
      dy      = S_MONE;
      calc_or = OR_UP;
    end else if (dir_sel[0]) begin
      dy      = S_ONE;
      calc_or = OR_DOWN;
    end
    cur_x = signed'({1'b0, act_x[idx]});
    cur_y = signed'({1'b0, act_y[idx]});
    nx    = cur_x + dx;
    ny    = cur_y + dy;
    off_x = nx[SW-1] || (nx >= MW);
    off_y = ny[SW-1] || (ny >= MH);

    if (nx[SW-1])     calc_tx = MW_M1;
    else if (nx >= MW) calc_tx = '0;
    else              calc_tx = nx[COORD_W-1:0];
    if (ny[SW-1])     calc_ty = MH_M1;
    else if (ny >= MH) calc_ty = '0;
    else              calc_ty = ny[COORD_W-1:0];

    calc_block = (WRAP == 0) && (off_x || off_y);
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      tgt_x <= '0;
      tgt_y <= '0;
      old_x <= '0;
      old_y <= '0;
      rd_q  <= '0;
      for (int i = 0; i < NUM_ACTORS; i++) begin
        act_x[i]  <= COORD_W'(START_X + i * START_STEP);
        act_y[i]  <= COORD_W'(START_Y);
        act_or[i] <= OR_RIGHT;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (pending) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (calc_any) act_or[idx] <= calc_or;
          tgt_x <= calc_tx;
          tgt_y <= calc_ty;
          if (!calc_any || calc_block) state <= S_DRAW;
          else                         state <= S_READ;
        end
        S_READ: begin
          if (map.ready) begin
            rd_q  <= map.read_sprite;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (rd_q == WALL_CODE) begin
            state <= S_DRAW;
          end else begin
            old_x      <= act_x[idx];
            old_y      <= act_y[idx];
            act_x[idx] <= tgt_x;
            act_y[idx] <= tgt_y;
            state      <= S_ERASE;
          end
        end
        S_ERASE: state <= S_GAP;
        S_GAP:   state <= S_DRAW;
        S_DRAW:  state <= S_NEXT;
        S_NEXT: begin
          if (idx == IDX_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= S_CALC;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign body = SPRITE_BASE + 5'(idx);

  // Map port is decoded from state so address and data line up with the strobe.
  always_comb begin
    map.get    = 1'b0;
    map.update = 1'b0;
    map.posx   = '0;
    map.posy   = '0;
    map.sprite = '0;
    case (state)
      S_READ: begin
        map.get  = 1'b1;
        map.posx = tgt_x;
        map.posy = tgt_y;
      end
      S_ERASE: begin
        map.update = 1'b1;
        map.posx   = old_x;
        map.posy   = old_y;
        map.sprite = EMPTY_CODE;
      end
      S_DRAW: begin
        map.update = 1'b1;
        map.posx   = act_x[idx];
        map.posy   = act_y[idx];
        map.sprite = blink ? {act_or[idx], body} : ALT_CODE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_actor_tile_mover.sv
// Directed bench: instance A uses defaults (wrap, 21-frame tick); instance B has no wrap,
// a 3-frame tick and actor 0 at x=0, for edge blocking, tick overrun and mid-pass reset.
module tb_actor_tile_mover;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic [7:0] s;
  } ev_t;

  logic        px_clk;
  logic        rst;
  logic        ef_a, ef_b;
  logic [15:0] dir_a, dir_b;
  logic        busy_a, busy_b;

  int dly_a, dly_b;
  logic [5:0] wx_a, wy_a, wx_b, wy_b;
  int wcnt_a, wcnt_b;

  int checks;
  int errors;

  ev_t ua[$];
  ev_t ga[$];
  ev_t ub[$];
  ev_t gb[$];
  int gcyc_a, gcyc_b, ovl_a, ovl_b, dbl_a, dbl_b, rise_a, rise_b;
  logic upd_prev_a, upd_prev_b, get_prev_a, get_prev_b, busy_prev_a, busy_prev_b;

  actor_tile_mover_if #(.COORD_W(6)) ifa ();
  actor_tile_mover_if #(.COORD_W(6)) ifb ();

  actor_tile_mover dut_a (
    .px_clk   (px_clk),
    .rst      (rst),
    .endframe (ef_a),
    .dir      (dir_a),
    .map      (ifa),
    .busy     (busy_a)
  );

  actor_tile_mover #(
    .MAXFRAMES (2),
    .WRAP      (0),
    .START_X   (0)
  ) dut_b (
    .px_clk   (px_clk),
    .rst      (rst),
    .endframe (ef_b),
    .dir      (dir_b),
    .map      (ifb),
    .busy     (busy_b)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  // Map read responders: ready after dly cycles of get, wall at (wx,wy).
  always @(negedge px_clk) begin
    if (rst) begin
      ifa.ready = 1'b0;
      ifa.read_sprite = 8'd0;
      wcnt_a = 0;
    end else if (ifa.ready) begin
      ifa.ready = 1'b0;
      wcnt_a = 0;
    end else if (ifa.get) begin
      if (wcnt_a >= dly_a) begin
        ifa.ready = 1'b1;
        ifa.read_sprite = (ifa.posx == wx_a && ifa.posy == wy_a) ? 8'd1 : 8'd0;
      end else begin
        wcnt_a++;
      end
    end
  end

  always @(negedge px_clk) begin
    if (rst) begin
      ifb.ready = 1'b0;
      ifb.read_sprite = 8'd0;
      wcnt_b = 0;
    end else if (ifb.ready) begin
      ifb.ready = 1'b0;
      wcnt_b = 0;
    end else if (ifb.get) begin
      if (wcnt_b >= dly_b) begin
        ifb.ready = 1'b1;
        ifb.read_sprite = (ifb.posx == wx_b && ifb.posy == wy_b) ? 8'd1 : 8'd0;
      end else begin
        wcnt_b++;
      end
    end
  end

  // Bus monitors: log writes and read requests, count protocol violations.
  always @(negedge px_clk) begin
    if (rst) begin
      ua.delete(); ga.delete(); ub.delete(); gb.delete();
      gcyc_a = 0; gcyc_b = 0; ovl_a = 0; ovl_b = 0;
      dbl_a = 0; dbl_b = 0; rise_a = 0; rise_b = 0;
    end else begin
      if (ifa.update) ua.push_back({ifa.posx, ifa.posy, ifa.sprite});
      if (ifa.get && !get_prev_a) ga.push_back({ifa.posx, ifa.posy, 8'd0});
      if (ifa.get) gcyc_a++;
      if (ifa.get && ifa.update) ovl_a++;
      if (ifa.update && upd_prev_a) dbl_a++;
      if (busy_a && !busy_prev_a) rise_a++;
      if (ifb.update) ub.push_back({ifb.posx, ifb.posy, ifb.sprite});
      if (ifb.get && !get_prev_b) gb.push_back({ifb.posx, ifb.posy, 8'd0});
      if (ifb.get) gcyc_b++;
      if (ifb.get && ifb.update) ovl_b++;
      if (ifb.update && upd_prev_b) dbl_b++;
      if (busy_b && !busy_prev_b) rise_b++;
    end
    upd_prev_a = ifa.update; get_prev_a = ifa.get; busy_prev_a = busy_a;
    upd_prev_b = ifb.update; get_prev_b = ifb.get; busy_prev_b = busy_b;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not complete");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge px_clk);
    rst = 1'b1; ef_a = 1'b0; ef_b = 1'b0; dir_a = '0; dir_b = '0;
    repeat (3) @(negedge px_clk);
    rst = 1'b0;
    @(negedge px_clk);
  endtask

  task automatic pulse_a(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge px_clk) ef_a = 1'b1;
      @(negedge px_clk) ef_a = 1'b0;
    end
  endtask

  task automatic pulse_b(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge px_clk) ef_b = 1'b1;
      @(negedge px_clk) ef_b = 1'b0;
    end
  endtask

  task automatic wait_pass_a(output bit ok);
    int t;
    t = 0;
    while (!busy_a && t < 200) begin @(negedge px_clk); t++; end
    while (busy_a && t < 2000) begin @(negedge px_clk); t++; end
    ok = (t < 200 || rise_a > 0) && !busy_a && (t < 2000);
    @(negedge px_clk);
  endtask

  task automatic wait_pass_b(output bit ok);
    int t;
    t = 0;
    while (!busy_b && t < 200) begin @(negedge px_clk); t++; end
    while (busy_b && t < 2000) begin @(negedge px_clk); t++; end
    ok = (t < 200 || rise_b > 0) && !busy_b && (t < 2000);
    @(negedge px_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge px_clk);
    checks++; if (ifa.get !== 1'b0) begin errors++; $display("FAIL rst_get_a got %b want 0", ifa.get); end
    checks++; if (ifa.update !== 1'b0) begin errors++; $display("FAIL rst_update_a got %b want 0", ifa.update); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy_a got %b want 0", busy_a); end
    checks++; if (ifa.posx !== 6'd0) begin errors++; $display("FAIL rst_posx_a got %0d want 0", ifa.posx); end
    checks++; if (ifa.posy !== 6'd0) begin errors++; $display("FAIL rst_posy_a got %0d want 0", ifa.posy); end
    checks++; if (ifa.sprite !== 8'd0) begin errors++; $display("FAIL rst_sprite_a got %h want 00", ifa.sprite); end
    checks++; if (ifb.get !== 1'b0) begin errors++; $display("FAIL rst_get_b got %b want 0", ifb.get); end
    checks++; if (ifb.update !== 1'b0) begin errors++; $display("FAIL rst_update_b got %b want 0", ifb.update); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL rst_busy_b got %b want 0", busy_b); end
    rst = 1'b0;
    @(negedge px_clk);
  endtask

  task automatic test_idle_pass();
    bit ok;
    ev_t exp;
    do_reset();
    pulse_a(20);
    repeat (4) @(negedge px_clk);
    checks++; if (rise_a !== 0) begin errors++; $display("FAIL idle_early_tick got %0d passes want 0", rise_a); end
    pulse_a(1);
    wait_pass_a(ok);
    checks++; if (!ok) begin errors++; $display("FAIL idle_timeout got busy=%b want pass complete", busy_a); end
    checks++; if (ua.size() !== 4) begin errors++; $display("FAIL idle_upd_count got %0d want 4", ua.size()); end
    for (int k = 0; k < 4; k++) begin
      exp = {6'(6 + 2 * k), 6'd6, 8'(2 + k)};
      checks++; if (ua[k] !== exp) begin errors++; $display("FAIL idle_upd%0d got %h want %h", k, ua[k], exp); end
    end
    checks++; if (ga.size() !== 0) begin errors++; $display("FAIL idle_get_count got %0d want 0", ga.size()); end
    checks++; if (dbl_a !== 0) begin errors++; $display("FAIL idle_update_width got %0d adjacent want 0", dbl_a); end
  endtask

  task automatic test_move_left();
    bit ok;
    ev_t exp;
    do_reset();
    dly_a = 0; wx_a = 6'd63; wy_a = 6'd63;
    dir_a = 16'h0008;
    pulse_a(21);
    wait_pass_a(ok);
    dir_a = '0;
    checks++; if (!ok) begin errors++; $display("FAIL left_timeout got busy=%b want pass complete", busy_a); end
    checks++; if (ga.size() !== 1) begin errors++; $display("FAIL left_get_count got %0d want 1", ga.size()); end
    exp = {6'd5, 6'd6, 8'd0};
    checks++; if (ga[0] !== exp) begin errors++; $display("FAIL left_get_addr got %h want %h", ga[0], exp); end
    checks++; if (ua.size() !== 5) begin errors++; $display("FAIL left_upd_count got %0d want 5", ua.size()); end
    exp = {6'd6, 6'd6, 8'h00};
    checks++; if (ua[0] !== exp) begin errors++; $display("FAIL left_erase got %h want %h", ua[0], exp); end
    exp = {6'd5, 6'd6, 8'h62};
    checks++; if (ua[1] !== exp) begin errors++; $display("FAIL left_draw got %h want %h", ua[1], exp); end
    exp = {6'd8, 6'd6, 8'h03};
    checks++; if (ua[2] !== exp) begin errors++; $display("FAIL left_actor1 got %h want %h", ua[2], exp); end
    checks++; if (ovl_a !== 0) begin errors++; $display("FAIL left_overlap got %0d want 0", ovl_a); end
  endtask

  task automatic test_wall();
    bit ok;
    ev_t exp;
    do_reset();
    dly_a = 0; wx_a = 6'd6; wy_a = 6'd5;
    dir_a = 16'h0002;
    pulse_a(21);
    wait_pass_a(ok);
    dir_a = '0;
    checks++; if (!ok) begin errors++; $display("FAIL wall_timeout got busy=%b want pass complete", busy_a); end
    exp = {6'd6, 6'd5, 8'd0};
    checks++; if (ga[0] !== exp) begin errors++; $display("FAIL wall_get_addr got %h want %h", ga[0], exp); end
    checks++; if (ua.size() !== 4) begin errors++; $display("FAIL wall_upd_count got %0d want 4", ua.size()); end
    exp = {6'd6, 6'd6, 8'h22};
    checks++; if (ua[0] !== exp) begin errors++; $display("FAIL wall_draw got %h want %h", ua[0], exp); end
    wx_a = 6'd63; wy_a = 6'd63;
  endtask

  task automatic test_wrap();
    bit ok, all_ok;
    int ub0, gb0;
    ev_t exp;
    do_reset();
    dly_a = 0; wx_a = 6'd63; wy_a = 6'd63;
    dir_a = 16'h0008;
    all_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pulse_a(21);
      wait_pass_a(ok);
      all_ok = all_ok & ok;
    end
    ub0 = ua.size(); gb0 = ga.size();
    pulse_a(21);
    wait_pass_a(ok);
    all_ok = all_ok & ok;
    dir_a = '0;
    checks++; if (!all_ok) begin errors++; $display("FAIL wrap_timeout got busy=%b want passes complete", busy_a); end
    exp = {6'd39, 6'd6, 8'd0};
    checks++; if (ga[gb0] !== exp) begin errors++; $display("FAIL wrap_get_addr got %h want %h", ga[gb0], exp); end
    exp = {6'd0, 6'd6, 8'h00};
    checks++; if (ua[ub0] !== exp) begin errors++; $display("FAIL wrap_erase got %h want %h", ua[ub0], exp); end
    exp = {6'd39, 6'd6, 8'h62};
    checks++; if (ua[ub0+1] !== exp) begin errors++; $display("FAIL wrap_draw got %h want %h", ua[ub0+1], exp); end

    do_reset();
    dly_b = 0; wx_b = 6'd63; wy_b = 6'd63;
    dir_b = 16'h0008;
    pulse_b(3);
    wait_pass_b(ok);
    dir_b = '0;
    checks++; if (!ok) begin errors++; $display("FAIL nowrap_timeout got busy=%b want pass complete", busy_b); end
    checks++; if (gb.size() !== 0) begin errors++; $display("FAIL nowrap_get_count got %0d want 0", gb.size()); end
    checks++; if (ub.size() !== 4) begin errors++; $display("FAIL nowrap_upd_count got %0d want 4", ub.size()); end
    exp = {6'd0, 6'd6, 8'h62};
    checks++; if (ub[0] !== exp) begin errors++; $display("FAIL nowrap_draw got %h want %h", ub[0], exp); end
  endtask

  task automatic test_back_to_back();
    int t;
    ev_t exp;
    do_reset();
    dly_b = 5; wx_b = 6'd63; wy_b = 6'd63;
    dir_b = 16'h4444;
    pulse_b(9);
    t = 0;
    while (!(rise_b == 2 && !busy_b) && t < 400) begin @(negedge px_clk); t++; end
    repeat (60) @(negedge px_clk);
    dir_b = '0;
    checks++; if (t >= 400) begin errors++; $display("FAIL b2b_timeout got %0d passes want 2", rise_b); end
    checks++; if (rise_b !== 2) begin errors++; $display("FAIL b2b_pass_count got %0d want 2", rise_b); end
    checks++; if (gb.size() !== 8) begin errors++; $display("FAIL b2b_get_count got %0d want 8", gb.size()); end
    checks++; if (gcyc_b !== 48) begin errors++; $display("FAIL b2b_get_cycles got %0d want 48", gcyc_b); end
    checks++; if (ub.size() !== 16) begin errors++; $display("FAIL b2b_upd_count got %0d want 16", ub.size()); end
    checks++; if (ovl_b !== 0) begin errors++; $display("FAIL b2b_overlap got %0d want 0", ovl_b); end
    checks++; if (dbl_b !== 0) begin errors++; $display("FAIL b2b_update_width got %0d want 0", dbl_b); end
    exp = {6'd7, 6'd6, 8'h00};
    checks++; if (ub[14] !== exp) begin errors++; $display("FAIL b2b_last_erase got %h want %h", ub[14], exp); end
    checks++; if ({ub[15].x, ub[15].y} !== {6'd8, 6'd6}) begin errors++; $display("FAIL b2b_last_draw got %0d,%0d want 8,6", ub[15].x, ub[15].y); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    ev_t exp;
    do_reset();
    dly_b = 5; wx_b = 6'd63; wy_b = 6'd63;
    dir_b = 16'h0888;
    pulse_b(3);
    t = 0;
    while (!(ifb.get && ifb.posx == 6'd3) && t < 300) begin @(negedge px_clk); t++; end
    checks++; if (t >= 300) begin errors++; $display("FAIL mid_read_timeout got get=%b want actor2 read", ifb.get); end
    rst = 1'b1;
    @(posedge px_clk);
    #1;
    checks++; if (ifb.get !== 1'b0) begin errors++; $display("FAIL mid_get got %b want 0", ifb.get); end
    checks++; if (ifb.update !== 1'b0) begin errors++; $display("FAIL mid_update got %b want 0", ifb.update); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy_b); end
    @(negedge px_clk);
    rst = 1'b0;
    dir_b = '0;
    repeat (10) @(negedge px_clk);
    checks++; if (ub.size() !== 0) begin errors++; $display("FAIL mid_no_strobe got %0d want 0", ub.size()); end
    dly_b = 0;
    pulse_b(3);
    wait_pass_b(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_after_timeout got busy=%b want pass complete", busy_b); end
    for (int k = 0; k < 4; k++) begin
      exp = {6'(2 * k), 6'd6, 8'(2 + k)};
      checks++; if (ub[k] !== exp) begin errors++; $display("FAIL mid_pos%0d got %h want %h", k, ub[k], exp); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; ef_a = 1'b0; ef_b = 1'b0; dir_a = '0; dir_b = '0;
    dly_a = 0; dly_b = 0;
    wx_a = 6'd63; wy_a = 6'd63; wx_b = 6'd63; wy_b = 6'd63;
    test_reset();
    test_idle_pass();
    test_move_left();
    test_wall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
